// File: rtl/line_fill_ctrl.sv
// Cache line-fill controller: fetches one 8-word line from memory, writes it
// into the data RAM beat by beat, then installs the tag and pulses done.
module line_fill_ctrl #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [TAG_W+INDEX_W-1:0] i_req_addr,
  output logic                     o_mem_rd_valid,
  input  logic                     i_mem_rd_ready,
  output logic [TAG_W+INDEX_W-1:0] o_mem_rd_addr,
  input  logic                     i_mem_data_valid,
  input  logic [DATA_W-1:0]        i_mem_data,
  output logic                     o_dwr,
  output logic [INDEX_W+2:0]       o_daddr,
  output logic [DATA_W-1:0]        o_ddata,
  output logic                     o_twr,
  output logic [INDEX_W-1:0]       o_taddr,
  output logic [TAG_W:0]           o_tdata,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_FILL = 3'd2,
    S_TAG  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [TAG_W+INDEX_W-1:0]   r_addr;
  logic [2:0]                 r_cnt;
  logic                       w_beat;
  logic [INDEX_W-1:0]         w_index;
  logic [TAG_W-1:0]           w_tag;

  assign w_index = r_addr[INDEX_W-1:0];
  assign w_tag   = r_addr[TAG_W+INDEX_W-1:INDEX_W];
  assign w_beat  = (r_state == S_FILL) && i_mem_data_valid;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latched line address and beat counter
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_addr <= '0;
      r_cnt  <= 3'd0;
    end else begin
      if ((r_state == S_IDLE) && i_req_valid) begin
        r_addr <= i_req_addr;
      end
      if ((r_state == S_REQ) && i_mem_rd_ready) begin
        r_cnt <= 3'd0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  // Next-state and output decode; outputs forced to idle values while reset is low
  always_comb begin
    w_next         = r_state;
    o_req_ready    = 1'b0;
    o_mem_rd_valid = 1'b0;
    o_mem_rd_addr  = r_addr;
    o_dwr          = 1'b0;
    o_daddr        = {w_index, r_cnt};
    o_ddata        = '0;
    o_twr          = 1'b0;
    o_taddr        = w_index;
    o_tdata        = '0;
    o_busy         = (r_state != S_IDLE);
    o_done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_next = S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        o_mem_rd_valid = 1'b1;
        if (i_mem_rd_ready) begin
          w_next = S_FILL;
        end else begin
          w_next = S_REQ;
        end
      end
      S_FILL: begin
        if (i_mem_data_valid) begin
          o_dwr   = 1'b1;
          o_ddata = i_mem_data;
          if (r_cnt == 3'd7) begin
            w_next = S_TAG;
          end else begin
            w_next = S_FILL;
          end
        end else begin
          w_next = S_FILL;
        end
      end
      S_TAG: begin
        o_twr   = 1'b1;
        o_tdata = {1'b1, w_tag};
        w_next  = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if (!i_reset) begin
      o_req_ready    = 1'b1;
      o_mem_rd_valid = 1'b0;
      o_mem_rd_addr  = '0;
      o_dwr          = 1'b0;
      o_daddr        = '0;
      o_ddata        = '0;
      o_twr          = 1'b0;
      o_taddr        = '0;
      o_tdata        = '0;
      o_busy         = 1'b0;
      o_done         = 1'b0;
    end else begin
      o_busy = (r_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl: fixed fills with hand-computed addresses,
// data, tag words and cycle positions of every write and done pulse.
module tb_line_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [15:0] mem_rd_addr;
  logic        mem_data_valid;
  logic [7:0]  mem_data;
  logic        dwr;
  logic [10:0] daddr;
  logic [7:0]  ddata;
  logic        twr;
  logic [7:0]  taddr;
  logic [8:0]  tdata;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [10:0] wa[$];
  logic [7:0]  wd[$];
  int          wcyc[$];
  int          dq[$];
  int          twr_n;
  int          tcyc;
  logic [7:0]  ta;
  logic [8:0]  td;
  int          rdv_n;
  int          rd_bad;
  logic [15:0] exp_rd_addr;

  line_fill_ctrl #(.INDEX_W(8), .TAG_W(8), .DATA_W(8)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .o_mem_rd_valid(mem_rd_valid), .i_mem_rd_ready(mem_rd_ready), .o_mem_rd_addr(mem_rd_addr),
    .i_mem_data_valid(mem_data_valid), .i_mem_data(mem_data),
    .o_dwr(dwr), .o_daddr(daddr), .o_ddata(ddata),
    .o_twr(twr), .o_taddr(taddr), .o_tdata(tdata),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Observe the DUT away from the rising edge
  always @(negedge clk) begin
    check("excl", 32'($countones({dwr, twr, mem_rd_valid, done}) <= 1), 32'd1);
    if (dwr) begin
      wa.push_back(daddr);
      wd.push_back(ddata);
      wcyc.push_back(cyc);
    end
    if (twr) begin
      twr_n++;
      ta = taddr;
      td = tdata;
      tcyc = cyc;
    end
    if (done) dq.push_back(cyc);
    if (mem_rd_valid) begin
      rdv_n++;
      if (mem_rd_addr !== exp_rd_addr) rd_bad++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa.delete(); wd.delete(); wcyc.delete(); dq.delete();
    twr_n = 0; tcyc = -1; ta = '0; td = '0; rdv_n = 0; rd_bad = 0;
  endtask

  task automatic do_fill(input logic [15:0] addr, input int rd_delay, input int gap,
                         input logic [7:0] d0, input int abort_after, input bit noise,
                         output int t0);
    clear_mon();
    exp_rd_addr = addr;
    req_valid = 1'b1;
    req_addr  = addr;
    t0 = cyc;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < rd_delay; i++) begin
      mem_rd_ready = 1'b0;
      step();
    end
    mem_rd_ready = 1'b1;
    step();
    mem_rd_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_data_valid = 1'b0;
        mem_data = 8'hEE;
        if (noise) begin
          req_valid = 1'b1;
          req_addr  = 16'hFFFF;
          #2;
          check("busy_noise", 32'(busy), 32'd1);
          check("ready_noise", 32'(req_ready), 32'd0);
        end
        step();
      end
      mem_data_valid = 1'b1;
      mem_data = d0 + 8'(b);
      step();
      mem_data_valid = 1'b0;
      req_valid = 1'b0;
      if (abort_after == b + 1) begin
        reset = 1'b0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dwr", 32'(dwr), 32'd0);
        step();
        reset = 1'b1;
        #2;
        check("abort_idle", 32'({busy, req_ready}), 32'b01);
        step(); step(); step();
        return;
      end
    end
    step(); step(); step();
  endtask

  task automatic check_fill(input string nm, input logic [10:0] a0, input logic [7:0] d0,
                            input int first_cyc, input int stride,
                            input logic [7:0] etaddr, input logic [8:0] etdata, input int dcyc);
    check({nm, "_nwr"}, 32'(wa.size()), 32'd8);
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      check({nm, "_daddr"}, 32'(wa[i]), 32'(a0 + 11'(i)));
      check({nm, "_ddata"}, 32'(wd[i]), 32'(d0 + 8'(i)));
      check({nm, "_wcyc"}, 32'(wcyc[i]), 32'(first_cyc + i * stride));
    end
    check({nm, "_ntwr"}, 32'(twr_n), 32'd1);
    check({nm, "_taddr"}, 32'(ta), 32'(etaddr));
    check({nm, "_tdata"}, 32'(td), 32'(etdata));
    check({nm, "_tcyc"}, 32'(tcyc), 32'(dcyc - 1));
    check({nm, "_ndone"}, 32'(dq.size()), 32'd1);
    if (dq.size() > 0) check({nm, "_dcyc"}, 32'(dq[0]), 32'(dcyc));
    else check({nm, "_dcyc"}, 32'hFFFF_FFFF, 32'(dcyc));
  endtask

  initial begin
    int t0;
    reset = 1'b0; req_valid = 1'b0; req_addr = 16'h0;
    mem_rd_ready = 1'b0; mem_data_valid = 1'b0; mem_data = 8'h0;
    exp_rd_addr = 16'h0;
    clear_mon();
    step(); step();
    #2;
    check("reset_ready_busy", 32'({req_ready, busy}), 32'b10);
    check("reset_strobes", 32'({mem_rd_valid, dwr, twr, done}), 32'd0);
    check("reset_addrs", 32'({daddr, taddr}), 32'd0);
    check("reset_tdata_rd", 32'({tdata, mem_rd_addr}), 32'd0);
    reset = 1'b1;
    step();

    // Basic fill, memory ready immediately, back-to-back beats
    do_fill(16'h3A05, 0, 0, 8'h10, 0, 1'b0, t0);
    check_fill("basic", 11'h028, 8'h10, t0 + 2, 1, 8'h05, 9'h13A, t0 + 11);
    check("basic_rdv", 32'(rdv_n), 32'd1);

    // Memory read accept delayed by 4 cycles
    do_fill(16'h3A05, 4, 0, 8'h40, 0, 1'b0, t0);
    check("delay_rdv", 32'(rdv_n), 32'd5);
    check("delay_rdaddr", 32'(rd_bad), 32'd0);
    check_fill("delay", 11'h028, 8'h40, t0 + 6, 1, 8'h05, 9'h13A, t0 + 15);

    // Alternate-cycle beats
    do_fill(16'hC312, 0, 1, 8'h80, 0, 1'b0, t0);
    check_fill("gap", 11'h090, 8'h80, t0 + 3, 2, 8'h12, 9'h1C3, t0 + 19);

    // Stray data while idle, stray requests while filling
    clear_mon();
    mem_data_valid = 1'b1; mem_data = 8'h99;
    step(); step();
    #2;
    check("idle_busy", 32'(busy), 32'd0);
    mem_data_valid = 1'b0;
    step();
    check("idle_nodwr", 32'(wa.size()), 32'd0);
    do_fill(16'h2B44, 0, 1, 8'hA0, 0, 1'b1, t0);
    check_fill("noise", 11'h220, 8'hA0, t0 + 3, 2, 8'h44, 9'h12B, t0 + 19);

    // Reset after the third beat aborts the fill
    do_fill(16'h7733, 0, 0, 8'h50, 3, 1'b0, t0);
    check("abort_nwr", 32'(wa.size()), 32'd3);
    check("abort_twr", 32'(twr_n), 32'd0);
    check("abort_done", 32'(dq.size()), 32'd0);
    do_fill(16'h5507, 0, 0, 8'h20, 0, 1'b0, t0);
    check_fill("after_abort", 11'h038, 8'h20, t0 + 2, 1, 8'h07, 9'h155, t0 + 11);

    // Two fills back to back with req_valid held
    clear_mon();
    exp_rd_addr = 16'h1234;
    req_valid = 1'b1; req_addr = 16'h1234;
    t0 = cyc;
    step();
    req_addr = 16'h5678;
    mem_rd_ready = 1'b1; mem_data_valid = 1'b1; mem_data = 8'hC3;
    for (int i = 0; i < 10; i++) step();
    exp_rd_addr = 16'h5678;
    for (int i = 0; i < 14; i++) step();
    req_valid = 1'b0; mem_rd_ready = 1'b0; mem_data_valid = 1'b0;
    step(); step();
    check("b2b_nwr", 32'(wa.size()), 32'd16);
    if (wa.size() == 16) begin
      check("b2b_a0", 32'(wa[0]), 32'h1A0);
      check("b2b_a7", 32'(wa[7]), 32'h1A7);
      check("b2b_a8", 32'(wa[8]), 32'h3C0);
      check("b2b_a15", 32'(wa[15]), 32'h3C7);
      check("b2b_c8", 32'(wcyc[8]), 32'(t0 + 14));
    end
    check("b2b_ndone", 32'(dq.size()), 32'd2);
    if (dq.size() == 2) begin
      check("b2b_d0", 32'(dq[0]), 32'(t0 + 11));
      check("b2b_d1", 32'(dq[1]), 32'(t0 + 23));
    end
    check("b2b_ntwr", 32'(twr_n), 32'd2);
    check("b2b_tdata", 32'(td), 32'h156);
    check("b2b_rdaddr", 32'(rd_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_fill_ctrl.md
LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 Parameter: INDEX_W, default 8, cache set-index width.
REQ-002 Parameter: TAG_W, default 8, tag width.
REQ-003 Parameter: DATA_W, default 8, data word width; line is fixed at 8 words (3-bit word counter).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset: sampled on rising clk, reset asserted when 0.
REQ-006 req_valid  in  1  miss-fill request from cache FSM.
REQ-007 req_ready  out  1  fill unit can accept a request.
REQ-008 req_addr  in  TAG_W+INDEX_W  line address {tag, index}.
REQ-009 mem_rd_valid  out  1  burst read request to main memory.
REQ-010 mem_rd_ready  in  1  memory accepts the read request.
REQ-011 mem_rd_addr  out  TAG_W+INDEX_W  latched line address.
REQ-012 mem_data_valid  in  1  one data beat present.
REQ-013 mem_data  in  DATA_W  beat data.
REQ-014 dwr  out  1  data RAM write enable.
REQ-015 daddr  out  INDEX_W+3  data RAM address {index, word}.
REQ-016 ddata  out  DATA_W  data RAM write data.
REQ-017 twr  out  1  tag RAM write enable.
REQ-018 taddr  out  INDEX_W  tag RAM address.
REQ-019 tdata  out  TAG_W+1  tag RAM write data {valid, tag}.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle fill-complete pulse.

Function
REQ-022 States SHALL be IDLE, REQ, FILL, TAG, DONE; encoding free.
REQ-023 IDLE: req_ready=1; on req_valid the block SHALL latch req_addr, go to REQ.
REQ-024 REQ: mem_rd_valid=1, mem_rd_addr=latched address; on mem_rd_ready go to FILL with word counter=0; otherwise hold.
REQ-025 FILL: each cycle with mem_data_valid=1 SHALL assert dwr in that cycle (combinational), daddr={index, counter}, ddata=mem_data, counter increments at edge.
REQ-026 FILL: cycle with mem_data_valid=0 SHALL hold state/counter, dwr=0; gaps of any length allowed.
REQ-027 Beat with counter=7 SHALL be written and counter wraps to 0; state goes to TAG.
REQ-028 TAG: twr=1 for exactly one cycle, taddr=index, tdata={1'b1, tag}; then DONE.
REQ-029 DONE: done=1 for exactly one cycle; then IDLE. A new request is accepted no earlier than the following cycle.
REQ-030 Minimum latency, back-to-back memory: request accepted cycle 0, REQ cycle 1, FILL cycles 2-9, twr cycle 10, done cycle 11.
REQ-031 mem_data_valid outside FILL SHALL be ignored (no dwr); req_valid outside IDLE SHALL be ignored, latched address unchanged.
REQ-032 dwr, twr, mem_rd_valid, done SHALL never be asserted in the same cycle as each other.
REQ-033 Exactly 8 dwr pulses and 1 twr pulse per completed fill, daddr word field 0..7 in order.

Reset
REQ-034 With reset=0 at a rising edge: state=IDLE, counter=0, latched address=0.
REQ-035 Outputs during/after reset: req_ready=1, busy=0; mem_rd_valid, dwr, twr, done=0; daddr, taddr, tdata, mem_rd_addr=0.
REQ-036 Reset mid-fill SHALL abort: no further dwr, no twr, no done; partially written words remain, tag untouched.

Verification
REQ-037 Fill req_addr=16'h3A05, mem_rd_ready=1 immediately, data 8'h10..8'h17 consecutive -> dwr at daddr 11'h028..11'h02F with 8'h10..8'h17, twr taddr=8'h05 tdata=9'h13A, done at cycle 11.
REQ-038 mem_rd_ready delayed 4 cycles -> mem_rd_valid held 5 cycles with stable mem_rd_addr, no dwr before FILL.
REQ-039 Beats with gaps (valid on alternate cycles) -> exactly 8 dwr, addresses contiguous, done 8 cycles later than REQ-037 case.
REQ-040 mem_data_valid=1 while IDLE and req_valid=1 while FILL -> no extra dwr, address latch unchanged, busy stays 1.
REQ-041 reset=0 after 3rd beat -> IDLE next cycle, only 3 dwr observed, no twr, no done; subsequent fill index 8'h07 completes normally.
REQ-042 Two fills back-to-back (req_valid held) -> second accepted the cycle after done, counter restarts at 0.
